// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, legal oversampling ratios,
// default word width and parity-type constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int DATA_WD_DEFAULT = 8;

    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

    localparam logic EVEN = 1'b0;
    localparam logic ODD  = 1'b1;

    // Anything other than 16 or 32 is treated as the slowest legal ratio.
    function automatic logic [5:0] legal_prescale(input logic [5:0] p);
        return (p == PRESCALE_16 || p == PRESCALE_32) ? p : PRESCALE_8;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line and frame configuration in, parallel word
// and status strobes out.
interface uart_rx_if #(
    parameter int DATA_WD = uart_pkg::DATA_WD_DEFAULT
);
    logic               RX_IN;
    logic               PAR_EN;
    logic               PAR_TYP;
    logic [5:0]         Prescale;
    logic [DATA_WD-1:0] P_DATA;
    logic               Data_Valid;
    logic               par_err;
    logic               stp_err;

    modport master (
        output RX_IN, PAR_EN, PAR_TYP, Prescale,
        input  P_DATA, Data_Valid, par_err, stp_err
    );

    modport slave (
        input  RX_IN, PAR_EN, PAR_TYP, Prescale,
        output P_DATA, Data_Valid, par_err, stp_err
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and 3-sample majority voter around the bit centre.
// Provides the recovered bit plus evaluation and end-of-bit flags to the FSM.
module uart_rx_sampler
    import uart_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       rx_in,
    input  logic [5:0] prescale,
    input  logic       count_en,
    input  logic       count_clr,
    output logic       sampled_bit,
    output logic       eval_point,
    output logic       bit_end
);
    logic [5:0] edge_cnt;
    logic [5:0] half;
    logic [1:0] early;

    assign half       = prescale >> 1;
    assign eval_point = (edge_cnt == half + 6'd1);
    assign bit_end    = (edge_cnt == prescale - 6'd1);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt <= '0;
        end else if (count_clr) begin
            edge_cnt <= '0;
        end else if (count_en) begin
            edge_cnt <= bit_end ? 6'd0 : edge_cnt + 6'd1;
        end
    end

    // The two earlier samples are held until the centre sample arrives, then
    // the vote is registered so it is stable for the FSM one edge later.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            early       <= 2'b11;
            sampled_bit <= 1'b1;
        end else if (count_en) begin
            if (edge_cnt == half - 6'd2) early[0] <= rx_in;
            if (edge_cnt == half - 6'd1) early[1] <= rx_in;
            if (edge_cnt == half) begin
                sampled_bit <= (early[0] & early[1]) | (early[0] & rx_in) | (early[1] & rx_in);
            end
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start/data/[parity]/stop deserializer with
// one-cycle valid and error strobes. Parity support requires UART_RX_PARITY_CHK_EN.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WD = DATA_WD_DEFAULT
) (
    input  logic     CLK,
    input  logic     RST,
    uart_rx_if.slave bus
);
    localparam int BIT_CNT_WD = $clog2(DATA_WD + 1);

    rx_state_t             state, state_nxt;
    logic [5:0]            p_lat;
    logic [BIT_CNT_WD-1:0] bit_cnt;
    logic [DATA_WD-1:0]    shift_reg;
    logic [DATA_WD-1:0]    data_reg;
    logic                  valid_reg;
    logic                  stp_err_reg;
    logic                  sampled_bit;
    logic                  eval_point;
    logic                  bit_end;
    logic                  cnt_en;
    logic                  cnt_clr;
    logic                  start_frame;
    logic                  shift_en;
    logic                  bit_inc;
    logic                  frame_done;
    logic                  frame_ok;

`ifdef UART_RX_PARITY_CHK_EN
    logic par_en_lat;
    logic par_typ_lat;
    logic par_bad;
    logic par_check;
    logic par_err_reg;
`else
    logic par_check;
    logic unused_par_cfg;
    assign unused_par_cfg = bus.PAR_EN ^ bus.PAR_TYP;
`endif

    uart_rx_sampler u_sampler (
        .CLK         (CLK),
        .RST         (RST),
        .rx_in       (bus.RX_IN),
        .prescale    (p_lat),
        .count_en    (cnt_en),
        .count_clr   (cnt_clr),
        .sampled_bit (sampled_bit),
        .eval_point  (eval_point),
        .bit_end     (bit_end)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        cnt_en      = 1'b0;
        cnt_clr     = 1'b0;
        start_frame = 1'b0;
        shift_en    = 1'b0;
        par_check   = 1'b0;
        bit_inc     = 1'b0;
        frame_done  = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.RX_IN) begin
                    start_frame = 1'b1;
                    cnt_en      = 1'b1;
                    state_nxt   = START;
                end else begin
                    cnt_clr = 1'b1;
                end
            end
            START: begin
                cnt_en = 1'b1;
                // A start bit that votes high was only a glitch on the line.
                if (eval_point && sampled_bit) begin
                    cnt_clr   = 1'b1;
                    state_nxt = IDLE;
                end else if (bit_end) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                cnt_en   = 1'b1;
                shift_en = eval_point;
                if (bit_end) begin
                    bit_inc = 1'b1;
                    if (bit_cnt == BIT_CNT_WD'(DATA_WD - 1)) begin
`ifdef UART_RX_PARITY_CHK_EN
                        state_nxt = par_en_lat ? PARITY : STOP;
`else
                        state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_CHK_EN
            PARITY: begin
                cnt_en    = 1'b1;
                par_check = eval_point;
                if (bit_end) state_nxt = STOP;
            end
`endif
            STOP: begin
                cnt_en = 1'b1;
                // Leaving at mid-stop lets a back-to-back start edge be caught.
                if (eval_point) begin
                    frame_done = 1'b1;
                    cnt_clr    = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            p_lat     <= PRESCALE_8;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            if (start_frame) p_lat <= legal_prescale(bus.Prescale);
            if (start_frame)  bit_cnt <= '0;
            else if (bit_inc) bit_cnt <= bit_cnt + BIT_CNT_WD'(1);
            if (shift_en) shift_reg <= {sampled_bit, shift_reg[DATA_WD-1:1]};
        end
    end

`ifdef UART_RX_PARITY_CHK_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_en_lat  <= 1'b0;
            par_typ_lat <= EVEN;
            par_bad     <= 1'b0;
            par_err_reg <= 1'b0;
        end else begin
            if (start_frame) begin
                par_en_lat  <= bus.PAR_EN;
                par_typ_lat <= bus.PAR_TYP;
                par_bad     <= 1'b0;
            end else if (par_check) begin
                par_bad <= sampled_bit ^ (^shift_reg) ^ par_typ_lat;
            end
            par_err_reg <= frame_done && par_bad;
        end
    end

    assign frame_ok    = sampled_bit && !par_bad;
    assign bus.par_err = par_err_reg;
`else
    assign frame_ok    = sampled_bit;
    assign bus.par_err = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            stp_err_reg <= 1'b0;
        end else begin
            valid_reg   <= frame_done && frame_ok;
            stp_err_reg <= frame_done && !sampled_bit;
            if (frame_done && frame_ok) data_reg <= shift_reg;
        end
    end

    assign bus.P_DATA     = data_reg;
    assign bus.Data_Valid = valid_reg;
    assign bus.stp_err    = stp_err_reg;

endmodule
